// File: rtl/lut_prog_pkg.sv
// Shared types and elaboration-time helpers for the programmable LogicNet neuron table.
package lut_prog_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2,
    ERROR  = 2'd3
  } state_t;

  function automatic int calc_nbeats(input int in_bits, input int out_bits, input int load_w);
    return ((1 << in_bits) * out_bits) / load_w;
  endfunction

  function automatic int calc_epb(input int load_w, input int out_bits);
    return load_w / out_bits;
  endfunction

  // A beat must carry whole entries and the table must split into whole beats.
  function automatic bit params_ok(input int in_bits, input int out_bits, input int load_w);
    if (in_bits <= 0 || out_bits <= 0 || load_w <= 0) return 1'b0;
    if ((load_w % out_bits) != 0) return 1'b0;
    if (load_w > (1 << in_bits) * out_bits) return 1'b0;
    return (((1 << in_bits) * out_bits) % load_w) == 0;
  endfunction

endpackage

// File: rtl/lut_prog_ram.sv
// Distributed truth-table RAM: beat-wide multi-entry write, single asynchronous read.
module lut_prog_ram
  import lut_prog_pkg::*;
#(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 1,
  parameter int LOAD_W   = 8,
  parameter int BEAT_W   = 5
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [BEAT_W-1:0]   wbeat_i,
  input  logic [LOAD_W-1:0]   wdata_i,
  input  logic [IN_BITS-1:0]  raddr_i,
  output logic [OUT_BITS-1:0] rdata_o
);

  localparam int DEPTH = 1 << IN_BITS;
  localparam int EPB   = calc_epb(LOAD_W, OUT_BITS);

  (* ram_style = "distributed" *) logic [OUT_BITS-1:0] mem_q [DEPTH];

  // Entry j of beat b lands at b*EPB + j; one beat fills EPB consecutive entries.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int j = 0; j < EPB; j++) begin
        mem_q[IN_BITS'(int'(wbeat_i) * EPB + j)] <= wdata_i[j*OUT_BITS +: OUT_BITS];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lut_neuron_prog.sv
// Run-time loadable neuron truth table: framed config-stream loader plus registered lookup.
module lut_neuron_prog
  import lut_prog_pkg::*;
#(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 1,
  parameter int LOAD_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [LOAD_W-1:0]   cfg_data,
  input  logic                cfg_last,
  output logic                cfg_done,
  output logic                cfg_err,
  input  logic [IN_BITS-1:0]  M0,
  output logic [OUT_BITS-1:0] M1,
  output logic                M1_valid
);

  localparam int NBEATS = calc_nbeats(IN_BITS, OUT_BITS, LOAD_W);
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

  if (!params_ok(IN_BITS, OUT_BITS, LOAD_W)) begin : g_bad_params
    $error("lut_neuron_prog: LOAD_W must be a multiple of OUT_BITS and divide DEPTH*OUT_BITS");
  end

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OUT_BITS-1:0] m1_q, m1_d;
  logic                m1_valid_q, m1_valid_d;
  logic [OUT_BITS-1:0] rdata;
  logic                xfer;

  assign cfg_ready = (state_q == LOAD);
  // A beat coinciding with cfg_start is dropped: the restart wins.
  assign xfer      = cfg_valid & cfg_ready & ~cfg_start;
  assign cfg_done  = (state_q == ACTIVE);
  assign cfg_err   = (state_q == ERROR);
  assign M1        = m1_q;
  assign M1_valid  = m1_valid_q;

  lut_prog_ram #(
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS),
    .LOAD_W   (LOAD_W),
    .BEAT_W   (CNT_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (xfer),
    .wbeat_i (cnt_q),
    .wdata_i (cfg_data),
    .raddr_i (M0),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (cfg_start) begin
      state_d = LOAD;
      cnt_d   = '0;
    end else if (state_q == LOAD && xfer) begin
      if (cnt_q == LAST_CNT) begin
        state_d = cfg_last ? ACTIVE : ERROR;
      end else if (cfg_last) begin
        state_d = ERROR;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    m1_valid_d = (state_q == ACTIVE) && !cfg_start;
    m1_d       = m1_valid_d ? rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      m1_q       <= '0;
      m1_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      m1_q       <= m1_d;
      m1_valid_q <= m1_valid_d;
    end
  end

endmodule

// File: doc/lut_neuron_prog.md
Name: lut_neuron_prog

Overview:
- Run-time writer for a LogicNet neuron truth table: loads a 2^IN_BITS x OUT_BITS table from a beat-wise config stream into distributed LUT RAM.
- Once loaded, serves registered lookups on the same M0/M1 interface as a fixed neuron ROM.
- Lets the team reprogram layer neurons in-field instead of resynthesising; sits between the config bus and the layer datapath.

Parameters:
- IN_BITS, 8, neuron input width; table depth DEPTH = 2^IN_BITS.
- OUT_BITS, 1, neuron output width per entry.
- LOAD_W, 8, config payload bits per beat; must be a multiple of OUT_BITS and divide DEPTH*OUT_BITS.
- NBEATS (localparam), DEPTH*OUT_BITS/LOAD_W (32 at defaults).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cfg_start  in  1  one-cycle pulse: begin a new table load.
- cfg_valid  in  1  config beat valid.
- cfg_ready  out  1  block accepts a beat (high only in LOAD).
- cfg_data  in  LOAD_W  packed entries; bits [OUT_BITS*(j+1)-1 : OUT_BITS*j] = entry (beat*LOAD_W/OUT_BITS + j).
- cfg_last  in  1  marks the final beat.
- cfg_done  out  1  table loaded and lookups valid (level).
- cfg_err  out  1  framing error latched (level).
- M0  in  IN_BITS  lookup address (integer value of M0).
- M1  out  OUT_BITS  registered table[M0].
- M1_valid  out  1  M1 corresponds to M0 sampled on the previous cycle, with a valid table.

Behaviour:
- Reset values: cfg_ready=0, cfg_done=0, cfg_err=0, M1=0, M1_valid=0, beat counter=0, state IDLE. Table RAM is not cleared.
- States: IDLE, LOAD, ACTIVE, ERROR.
- IDLE: cfg_start -> LOAD, beat counter cleared.
- LOAD:
  - cfg_ready=1. A beat transfers on cfg_valid & cfg_ready.
  - On transfer, write LOAD_W/OUT_BITS entries at base beat*LOAD_W/OUT_BITS, then increment the counter.
  - Transfer with counter = NBEATS-1 and cfg_last=1 -> ACTIVE, cfg_done=1.
  - Transfer with cfg_last=1 and counter < NBEATS-1 (early last) -> ERROR. That beat is still written.
  - Transfer with counter = NBEATS-1 and cfg_last=0 (missing last) -> ERROR.
  - cfg_valid low: hold state and counter; no timeout.
- ACTIVE:
  - Every cycle, M1 <= table[M0] and M1_valid <= 1. Latency is exactly 1 cycle.
  - cfg_valid is ignored (cfg_ready=0).
- ERROR: cfg_err=1, cfg_done=0, M1_valid=0, M1 held at 0.
- cfg_start in any state, including mid-LOAD or ERROR, takes effect next cycle:
  - state -> LOAD, counter=0, cfg_done=0, cfg_err=0, M1_valid=0.
  - A beat presented in the same cycle as cfg_start is not accepted (cfg_ready is 0 that cycle unless already in LOAD, where start has priority and the beat is dropped).
- Outside ACTIVE: M1=0, M1_valid=0.
- Write and read never overlap: reads occur only in ACTIVE, writes only in LOAD. No read-during-write hazard, so the RAM may be plain distributed RAM.
- rst mid-LOAD -> IDLE. Partially written table contents persist but are unusable until a full reload (cfg_done=0).
- Counter width: clog2(NBEATS). It does not wrap, because the terminal beat always leaves LOAD.

Decomposition:
- Shared package lut_prog_pkg holds:
  - state enum {IDLE, LOAD, ACTIVE, ERROR};
  - functions computing NBEATS and the entries-per-beat constant;
  - a parameter-legality check function used by an elaboration-time assertion.
- One sub-module is natural: lut_prog_ram.
  - DEPTH x OUT_BITS distributed RAM, rom_style/ram_style "distributed".
  - Write port: LOAD_W-wide masked multi-entry write at beat granularity.
  - Read port: one asynchronous read; the parent registers M1.

Test Plan:
- Full load at defaults:
  - Stimulus: 32 beats with cfg_data=8'hA5 each, cfg_last on beat 31.
  - Required: cfg_done=1 the cycle after beat 31.
  - Then M0=0 -> M1=1 and M0=1 -> M1=0 (bit0=1, bit1=0 of A5), each one cycle later with M1_valid=1.
- Back-pressure:
  - Stimulus: cfg_valid toggled randomly during a load with pattern beat k = k.
  - Required: all 32 beats accepted. M0=8'h08 -> M1 = bit0 of beat 1 = 1; M0=8'h10 -> M1 = bit0 of beat 2 = 0.
- Early last:
  - Stimulus: cfg_last asserted on beat 5.
  - Required: cfg_err=1, cfg_done=0, M1_valid=0. A following cfg_start clears cfg_err, and a clean reload reaches cfg_done=1.
- Missing last:
  - Stimulus: 32 beats with no cfg_last.
  - Required: cfg_err=1 after beat 31; a 33rd beat sees cfg_ready=0.
- Restart and reset mid-load:
  - Stimulus: cfg_start after 10 beats.
  - Required: counter restarts at 0, and a full 32-beat load is needed for cfg_done.
  - Stimulus: rst asserted mid-load.
  - Required: all outputs at reset values; next cfg_start works.
- Reprogram equivalence:
  - Stimulus: load a table equal to a known fixed neuron truth table, sweep M0 = 0..255.
  - Required: M1 matches the golden table at every address, latency 1.
